// File: rtl/zjh_timer_ctrl.sv
// Sequencer for a cascaded 74HC161-style counter chain: one-shot/periodic timer
// that drives load/enable pins, watches terminal count and reports tick/done/busy.
`timescale 1ns/1ps
module zjh_timer_ctrl #(
    parameter  int unsigned STAGES = 2,
    localparam int unsigned W      = 4 * STAGES
) (
    input  logic         Clk,
    input  logic         MR,
    input  logic         start,
    input  logic         stop,
    input  logic         pause,
    input  logic         mode,
    input  logic [W-1:0] len,
    output logic         busy,
    output logic         tick,
    output logic         done,
    output logic         err,
    output logic         cnt_PE,
    output logic         cnt_Cep,
    output logic         cnt_Cet,
    output logic [W-1:0] cnt_D,
    input  logic         cnt_TC
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_e;

    state_e       state_q, state_d;
    logic [W-1:0] len_q, len_d;
    logic         mode_q, mode_d;
    logic         tick_q, tick_d;
    logic         done_q, done_d;
    logic         err_q, err_d;
    logic         pe_c, cep_c;

    always_ff @(posedge Clk or posedge MR) begin
        if (MR) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            mode_q  <= 1'b0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            mode_q  <= mode_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next state, status pulses and chain load/parallel-enable control
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        mode_d  = mode_q;
        tick_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        pe_c    = 1'b1;
        cep_c   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!stop && start) begin
                    if (len != '0) begin
                        len_d   = len;
                        mode_d  = mode;
                        state_d = S_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                pe_c    = 1'b0;
                state_d = stop ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (!pause) begin
                    cep_c = 1'b1;
                    if (cnt_TC) begin
                        tick_d = 1'b1;
                        if (mode_q) begin
                            pe_c = 1'b0;
                        end else begin
                            // Leave the chain parked at all-ones after a one-shot
                            cep_c   = 1'b0;
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Trickle enable kept free of cnt_TC, since the chain's TC is gated by it
    assign cnt_Cet = (state_q == S_RUN) && !stop && !pause;
    assign cnt_PE  = pe_c;
    assign cnt_Cep = cep_c;
    assign cnt_D   = W'(0) - len_q;
    assign busy    = (state_q != S_IDLE);
    assign tick    = tick_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule
